// File: rtl/rsa_job_scheduler.sv
// RSA sequencing controller: loads primes, runs key generation once per load, then
// round-robins one mod_exp engine between encrypt/decrypt requesters with a held response.
module rsa_job_scheduler #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_load,
  input  logic [WIDTH-1:0]     p_in,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 key_ready,
  input  logic                 enc_valid,
  output logic                 enc_ready,
  input  logic [WIDTH-1:0]     enc_msg,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [WIDTH-1:0]     dec_msg,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_data,
  output logic                 rsp_is_enc,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     kg_p,
  output logic [WIDTH-1:0]     kg_q,
  output logic                 kg_restart,
  input  logic                 kg_finish,
  output logic                 ex_restart,
  output logic                 ex_encrypt,
  output logic [WIDTH-1:0]     ex_msg,
  input  logic                 ex_finish,
  input  logic [2*WIDTH-1:0]   ex_result,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam logic [2:0] S_NOKEY    = 3'd0;
  localparam logic [2:0] S_KG_START = 3'd1;
  localparam logic [2:0] S_KG_RUN   = 3'd2;
  localparam logic [2:0] S_READY    = 3'd3;
  localparam logic [2:0] S_SETTLE   = 3'd4;
  localparam logic [2:0] S_EX_START = 3'd5;
  localparam logic [2:0] S_EX_RUN   = 3'd6;
  localparam logic [2:0] S_RESP     = 3'd7;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   kg_p_q, kg_p_d, kg_q_q, kg_q_d;
  logic [WIDTH-1:0]   ex_msg_q, ex_msg_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               key_ready_q, key_ready_d;
  logic               err_timeout_q, err_timeout_d;
  logic               last_enc_q, last_enc_d;
  logic               ex_encrypt_q, ex_encrypt_d;
  logic               rsp_is_enc_q, rsp_is_enc_d;
  logic               rsp_err_q, rsp_err_d;

  logic key_accept, can_grant, enc_fire, dec_fire;
  logic blanked, timed_out;

  assign key_accept = key_load && (state_q == S_NOKEY || state_q == S_READY);
  // A competing key_load wins over a grant so no handshake completes without being served.
  assign can_grant  = (state_q == S_READY) && key_ready_q && !key_load;
  // Only the round-robin winner sees ready, so a tie never completes two handshakes.
  assign enc_ready  = can_grant && !(dec_valid && last_enc_q);
  assign dec_ready  = can_grant && !(enc_valid && !last_enc_q);
  assign enc_fire   = enc_valid && enc_ready;
  assign dec_fire   = dec_valid && dec_ready;

  // Count is zero only in the first run cycle, which masks a finish left over from a prior run.
  assign blanked    = (cnt_q == '0);
  assign timed_out  = (cnt_q == TIMEOUT_C);

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path through the case infers a latch.
    state_d       = state_q;
    kg_p_d        = kg_p_q;
    kg_q_d        = kg_q_q;
    ex_msg_d      = ex_msg_q;
    rsp_data_d    = rsp_data_q;
    cnt_d         = cnt_q;
    key_ready_d   = key_ready_q;
    err_timeout_d = err_timeout_q;
    last_enc_d    = last_enc_q;
    ex_encrypt_d  = ex_encrypt_q;
    rsp_is_enc_d  = rsp_is_enc_q;
    rsp_err_d     = rsp_err_q;

    if (key_accept) begin
      kg_p_d        = p_in;
      kg_q_d        = q_in;
      key_ready_d   = 1'b0;
      err_timeout_d = 1'b0;
      state_d       = S_KG_START;
    end else begin
      case (state_q)
        S_KG_START: begin
          cnt_d   = '0;
          state_d = S_KG_RUN;
        end
        S_KG_RUN: begin
          if (kg_finish && !blanked) begin
            key_ready_d = 1'b1;
            state_d     = S_READY;
          end else if (timed_out) begin
            err_timeout_d = 1'b1;
            state_d       = S_NOKEY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_READY: begin
          if (enc_fire) begin
            ex_msg_d     = enc_msg;
            ex_encrypt_d = 1'b1;
            rsp_is_enc_d = 1'b1;
            last_enc_d   = 1'b1;
            state_d      = S_SETTLE;
          end else if (dec_fire) begin
            ex_msg_d     = dec_msg;
            ex_encrypt_d = 1'b0;
            rsp_is_enc_d = 1'b0;
            last_enc_d   = 1'b0;
            state_d      = S_SETTLE;
          end
        end
        S_SETTLE:   state_d = S_EX_START;
        S_EX_START: begin
          cnt_d   = '0;
          state_d = S_EX_RUN;
        end
        S_EX_RUN: begin
          if (ex_finish && !blanked) begin
            rsp_data_d = ex_result;
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
          end else if (timed_out) begin
            rsp_data_d    = '0;
            rsp_err_d     = 1'b1;
            err_timeout_d = 1'b1;
            state_d       = S_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) state_d = S_READY;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_NOKEY;
      kg_p_q        <= '0;
      kg_q_q        <= '0;
      ex_msg_q      <= '0;
      rsp_data_q    <= '0;
      cnt_q         <= '0;
      key_ready_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      last_enc_q    <= 1'b0;
      ex_encrypt_q  <= 1'b0;
      rsp_is_enc_q  <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      kg_p_q        <= kg_p_d;
      kg_q_q        <= kg_q_d;
      ex_msg_q      <= ex_msg_d;
      rsp_data_q    <= rsp_data_d;
      cnt_q         <= cnt_d;
      key_ready_q   <= key_ready_d;
      err_timeout_q <= err_timeout_d;
      last_enc_q    <= last_enc_d;
      ex_encrypt_q  <= ex_encrypt_d;
      rsp_is_enc_q  <= rsp_is_enc_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign key_ready   = key_ready_q;
  assign err_timeout = err_timeout_q;
  assign kg_p        = kg_p_q;
  assign kg_q        = kg_q_q;
  assign ex_msg      = ex_msg_q;
  assign ex_encrypt  = ex_encrypt_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_is_enc  = rsp_is_enc_q;
  assign rsp_err     = rsp_err_q;
  assign kg_restart  = (state_q == S_KG_START);
  assign ex_restart  = (state_q == S_EX_START);
  assign rsp_valid   = (state_q == S_RESP);
  assign busy        = (state_q != S_NOKEY) && (state_q != S_READY);

endmodule
